// File: rtl/int_to_fp.sv
// int_to_fp: multi-cycle conversion of a 32-bit two's-complement integer
// into a 1/6/25 floating-point word (sign [31], biased exponent [30:25],
// 25-bit mantissa [24:0] with a hidden leading 1). Normalisation shifts the
// magnitude left one bit per cycle, so latency depends on the leading-zero
// count. The mantissa is truncated; the dropped bits only set the inexact
// status code.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - asynchronous, active-low
//   start      - conversion request, only honoured while idle
//   int_in     - signed integer operand, sampled together with start
//   busy       - high while a conversion is in flight
//   done       - one-cycle pulse when data_out/status_out are updated
//   data_out   - converted float, held until the next conversion completes
//   status_out - 0001 exact, 1111 inexact (0011 overflow / 0111 underflow
//                are part of the status encoding but cannot occur here)
module int_to_fp #(
    parameter int BIAS = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b1111;

    // Exponent of an unshifted magnitude whose MSB sits at bit 31.
    localparam logic [5:0] EXP_INIT = 6'(BIAS + 31);

    state_t        state;
    logic          sign;
    logic [31:0]   mag;
    logic [5:0]    exp_work;
    logic          zero;

    logic signed [31:0] int_s;
    logic        [31:0] abs_in;

    // -2^31 negates to itself; read as unsigned that is the correct 2^31.
    assign int_s  = int_in;
    assign abs_in = int_s[31] ? 32'(-int_s) : 32'(int_s);

    assign busy = (state != IDLE);

    // Truncating pack of a normalised magnitude; returns {status, word}.
    function automatic logic [35:0] pack_result(
        input logic        s,
        input logic [5:0]  e,
        input logic [31:0] m,
        input logic        z
    );
        logic [3:0] st;
        if (z) begin
            pack_result = {ST_EXACT, 32'h0000_0000};
        end else begin
            st          = (m[5:0] != 6'd0) ? ST_INEXACT : ST_EXACT;
            pack_result = {st, s, e, m[30:6]};
        end
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            data_out   <= 32'h0000_0000;
            status_out <= 4'b0000;
            sign       <= 1'b0;
            mag        <= 32'h0000_0000;
            exp_work   <= 6'd0;
            zero       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign     <= int_s[31];
                        mag      <= abs_in;
                        exp_work <= EXP_INIT;
                        zero     <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (mag == 32'h0000_0000) begin
                        zero  <= 1'b1;
                        state <= PACK;
                    end else if (mag[31]) begin
                        state <= PACK;
                    end else begin
                        mag      <= mag << 1;
                        exp_work <= exp_work - 6'd1;
                    end
                end
                PACK: begin
                    {status_out, data_out} <= pack_result(sign, exp_work, mag, zero);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
